sdram_port_arbiter: RTL and testbench

- Shares the single native port of the SDRAM controller between two requesters.
  - Requester 0: the 6502 CPU bus bridge.
  - Requester 1: the SD-card DMA engine.
- Serialises accesses with one transaction outstanding at a time.
- Routes read data back to the requester that issued the read.
- Guards against a lost read completion with a timeout counter.
- Sits between the bus-decode/DMA logic and the SDRAM controller inside super6502.

---
 rtl/sdram_port_arbiter_pkg.sv | 22 ++
 rtl/sdram_port_arbiter_if.sv | 56 +++++
 rtl/sdram_port_arbiter_pick.sv | 21 ++
 rtl/sdram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_arb_pkg: shared types for the SDRAM port arbiter.
//   state_t  - arbiter FSM states (IDLE, ISSUE, WAIT_RD)
//   owner_t  - id of the requester that owns the current transaction
//   grant_owner() - converts a one-hot grant into an owner id
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_CPU = 1'b0;
  localparam owner_t OWNER_DMA = 1'b1;

  function automatic owner_t grant_owner(input logic [1:0] grant);
    return grant[1] ? OWNER_DMA : OWNER_CPU;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: bundles both requester ports and the SDRAM
// controller native port.
//   rq0_* : CPU bridge request/response  (valid/ready/we/addr/wdata, rvalid/rdata/err)
//   rq1_* : SD-card DMA request/response (same set)
//   sdr_* : controller command (addr/wdata/wr/rd) and status/read data (busy/rd_valid/rdata)
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system (requesters + controller)
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              rq0_valid;
  logic              rq0_ready;
  logic              rq0_we;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq0_rvalid;
  logic [DATA_W-1:0] rq0_rdata;
  logic              rq0_err;

  logic              rq1_valid;
  logic              rq1_ready;
  logic              rq1_we;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq1_rvalid;
  logic [DATA_W-1:0] rq1_rdata;
  logic              rq1_err;

  logic [ADDR_W-1:0] sdr_addr;
  logic [DATA_W-1:0] sdr_wdata;
  logic              sdr_wr;
  logic              sdr_rd;
  logic              sdr_busy;
  logic              sdr_rd_valid;
  logic [DATA_W-1:0] sdr_rdata;

  modport slave (
    input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    output rq0_ready, rq0_rvalid, rq0_rdata, rq0_err,
    input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    output rq1_ready, rq1_rvalid, rq1_rdata, rq1_err,
    output sdr_addr, sdr_wdata, sdr_wr, sdr_rd,
    input  sdr_busy, sdr_rd_valid, sdr_rdata
  );

  modport master (
    output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    input  rq0_ready, rq0_rvalid, rq0_rdata, rq0_err,
    output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    input  rq1_ready, rq1_rvalid, rq1_rdata, rq1_err,
    input  sdr_addr, sdr_wdata, sdr_wr, sdr_rd,
    output sdr_busy, sdr_rd_valid, sdr_rdata
  );
endinterface

// File: rtl/sdram_port_arbiter_pick.sv
// sdram_arb_pick: combinational winner select.
//   valid  in  [1:0]  request valids, bit0 = CPU, bit1 = DMA
//   rr_ptr in         requester preferred when both are valid
//   grant  out [1:0]  one-hot grant (all zero when nobody requests)
// A lone requester always wins regardless of rr_ptr.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  owner_t     rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (rr_ptr == OWNER_DMA) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller native port between the
// 6502 CPU bridge (requester 0) and the SD-card DMA engine (requester 1).
// One transaction is outstanding at a time; read data is routed back to the
// requester that issued the read, and a lost read completion is reported
// after RD_TIMEOUT cycles with err=1 and rdata=0.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : sdram_port_arbiter_if.slave (rq0_*, rq1_*, sdr_*)
// Build option: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break;
// otherwise the CPU always wins ties.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int RD_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  sdram_port_arbiter_if.slave bus
);

  localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t            state_reg;
  owner_t            owner_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] sdr_addr_reg;
  logic [DATA_W-1:0] sdr_wdata_reg;
  logic              sdr_wr_reg;
  logic              sdr_rd_reg;
  logic              rq0_rvalid_reg, rq1_rvalid_reg;
  logic              rq0_err_reg, rq1_err_reg;
  logic [DATA_W-1:0] rq0_rdata_reg, rq1_rdata_reg;

  logic [1:0]        grant;
  owner_t            rr_ptr;
  owner_t            win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_done;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  owner_t rr_reg;
  assign rr_ptr = rr_reg;
`else
  assign rr_ptr = OWNER_CPU;
`endif

  sdram_arb_pick u_pick (
    .valid  ({bus.rq1_valid, bus.rq0_valid}),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  // Ready is only offered in IDLE, so a request is never taken while
  // another transaction is still in flight.
  assign bus.rq0_ready = (state_reg == IDLE) && grant[0];
  assign bus.rq1_ready = (state_reg == IDLE) && grant[1];

  assign win       = grant_owner(grant);
  assign sel_we    = grant[1] ? bus.rq1_we    : bus.rq0_we;
  assign sel_addr  = grant[1] ? bus.rq1_addr  : bus.rq0_addr;
  assign sel_wdata = grant[1] ? bus.rq1_wdata : bus.rq0_wdata;

  // Read completion: data arriving on the expiry cycle still counts as success.
  always_comb begin
    rd_done = 1'b0;
    rd_err  = 1'b0;
    rd_data = '0;
    if (state_reg == WAIT_RD) begin
      if (bus.sdr_rd_valid) begin
        rd_done = 1'b1;
        rd_data = bus.sdr_rdata;
      end else if (cnt_reg == CNT_LAST) begin
        rd_done = 1'b1;
        rd_err  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWNER_CPU;
      cnt_reg        <= '0;
      sdr_addr_reg   <= '0;
      sdr_wdata_reg  <= '0;
      sdr_wr_reg     <= 1'b0;
      sdr_rd_reg     <= 1'b0;
      rq0_rvalid_reg <= 1'b0;
      rq1_rvalid_reg <= 1'b0;
      rq0_err_reg    <= 1'b0;
      rq1_err_reg    <= 1'b0;
      rq0_rdata_reg  <= '0;
      rq1_rdata_reg  <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_reg         <= OWNER_CPU;
`endif
    end else begin
      rq0_rvalid_reg <= rd_done && (owner_reg == OWNER_CPU);
      rq1_rvalid_reg <= rd_done && (owner_reg == OWNER_DMA);
      rq0_err_reg    <= rd_done && rd_err && (owner_reg == OWNER_CPU);
      rq1_err_reg    <= rd_done && rd_err && (owner_reg == OWNER_DMA);
      if (rd_done && (owner_reg == OWNER_CPU)) rq0_rdata_reg <= rd_data;
      if (rd_done && (owner_reg == OWNER_DMA)) rq1_rdata_reg <= rd_data;

      case (state_reg)
        IDLE: begin
          if (|grant) begin
            // Command registers double as the ISSUE-state outputs.
            owner_reg     <= win;
            sdr_addr_reg  <= sel_addr;
            sdr_wdata_reg <= sel_wdata;
            sdr_wr_reg    <= sel_we;
            sdr_rd_reg    <= !sel_we;
            state_reg     <= ISSUE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_reg        <= ~win;
`endif
          end
        end
        ISSUE: begin
          if (!bus.sdr_busy) begin
            sdr_addr_reg  <= '0;
            sdr_wdata_reg <= '0;
            sdr_wr_reg    <= 1'b0;
            sdr_rd_reg    <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= sdr_wr_reg ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (rd_done) state_reg <= IDLE;
          else         cnt_reg   <= cnt_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.sdr_addr   = sdr_addr_reg;
  assign bus.sdr_wdata  = sdr_wdata_reg;
  assign bus.sdr_wr     = sdr_wr_reg;
  assign bus.sdr_rd     = sdr_rd_reg;
  assign bus.rq0_rvalid = rq0_rvalid_reg;
  assign bus.rq0_rdata  = rq0_rdata_reg;
  assign bus.rq0_err    = rq0_err_reg;
  assign bus.rq1_rvalid = rq1_rvalid_reg;
  assign bus.rq1_rdata  = rq1_rdata_reg;
  assign bus.rq1_err    = rq1_err_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed vector table of single
// transactions against a small SDRAM controller model, plus hand-written
// sequences for contention, mid-read reset and stray read data.
module tb_sdram_port_arbiter;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 16;
  localparam int RD_TIMEOUT = 64;
  localparam int RD_LAT     = 3;   // model: accept -> sdr_rd_valid cycles

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SDRAM controller model ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [logic [23:0]];
  int          busy_left = 0;
  int          busy_seen = 0;
  int          accept_count = 0;
  int          accept_cyc = 0;
  int          pending = 0;
  logic        respond_en = 1'b1;
  logic        stray = 1'b0;
  logic [15:0] pend_data = '0;
  logic [23:0] acc_addr = '0;
  logic [15:0] acc_wdata = '0;
  logic        acc_wr = 1'b0;

  // Runs on the falling edge: decides busy/rd_valid for the next rising edge.
  always @(negedge clk) begin
    bus.sdr_rd_valid = 1'b0;
    bus.sdr_rdata    = '0;
    if (pending > 0) begin
      pending = pending - 1;
      if (pending == 0) begin
        bus.sdr_rd_valid = 1'b1;
        bus.sdr_rdata    = pend_data;
      end
    end
    if (stray) begin
      bus.sdr_rd_valid = 1'b1;
      bus.sdr_rdata    = 16'hDEAD;
      stray            = 1'b0;
    end
    if ((bus.sdr_wr || bus.sdr_rd) && busy_left > 0) begin
      bus.sdr_busy = 1'b1;
      busy_left    = busy_left - 1;
      busy_seen    = busy_seen + 1;
    end else begin
      bus.sdr_busy = 1'b0;
      if (bus.sdr_wr || bus.sdr_rd) begin
        accept_count = accept_count + 1;
        accept_cyc   = cyc + 1;
        acc_addr     = bus.sdr_addr;
        acc_wdata    = bus.sdr_wdata;
        acc_wr       = bus.sdr_wr;
        if (bus.sdr_wr) mem[bus.sdr_addr] = bus.sdr_wdata;
        else if (respond_en) begin
          pending   = RD_LAT;
          pend_data = mem.exists(bus.sdr_addr) ? mem[bus.sdr_addr] : 16'h0000;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic apply_reset();
    wait_cyc();
    rst = 1'b1;
    wait_cyc();
    rst = 1'b0;
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.rq0_ready, bus.rq0_rvalid, bus.rq0_rdata, bus.rq0_err,
            bus.rq1_ready, bus.rq1_rvalid, bus.rq1_rdata, bus.rq1_err,
            bus.sdr_addr, bus.sdr_wdata, bus.sdr_wr, bus.sdr_rd};
  endfunction

  typedef struct {
    logic        port;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          busy;
    logic        respond;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string pfx);
    int   base_acc, base_busy, lat;
    logic got, wrong, other_rdy, err;
    logic [15:0] data;
    wait_cyc();
    base_acc   = accept_count;
    base_busy  = busy_seen;
    busy_left  = v.busy;
    respond_en = v.respond;
    if (v.port == 1'b0) begin
      bus.rq0_valid = 1'b1; bus.rq0_we = v.we; bus.rq0_addr = v.addr; bus.rq0_wdata = v.wdata;
    end else begin
      bus.rq1_valid = 1'b1; bus.rq1_we = v.we; bus.rq1_addr = v.addr; bus.rq1_wdata = v.wdata;
    end
    got = 1'b0;
    other_rdy = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((v.port ? bus.rq1_ready : bus.rq0_ready) == 1'b1) begin
        got = 1'b1;
        other_rdy = v.port ? bus.rq0_ready : bus.rq1_ready;
      end else wait_cyc();
    end
    check({pfx, " grant"}, got, 1'b1);
    check({pfx, " other_ready"}, other_rdy, 1'b0);
    @(posedge clk);
    #1;
    bus.rq0_valid = 1'b0;
    bus.rq1_valid = 1'b0;
    for (int i = 0; i < 40 && accept_count == base_acc; i++) wait_cyc();
    check({pfx, " accepts"}, accept_count - base_acc, 1);
    check({pfx, " busy_hold"}, busy_seen - base_busy, v.busy);
    check({pfx, " cmd"}, {acc_wr, acc_addr}, {v.we, v.addr});
    if (v.we) begin
      check({pfx, " wdata"}, acc_wdata, v.wdata);
      wrong = 1'b0;
      for (int i = 0; i < 6; i++) begin
        wait_cyc();
        if (bus.rq0_rvalid || bus.rq1_rvalid) wrong = 1'b1;
      end
      check({pfx, " write_no_rvalid"}, wrong, 1'b0);
    end else begin
      got = 1'b0; wrong = 1'b0; lat = 0; data = '0; err = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        wait_cyc();
        if ((v.port ? bus.rq0_rvalid : bus.rq1_rvalid) == 1'b1) wrong = 1'b1;
        if ((v.port ? bus.rq1_rvalid : bus.rq0_rvalid) == 1'b1) begin
          got  = 1'b1;
          lat  = cyc - accept_cyc;
          data = v.port ? bus.rq1_rdata : bus.rq0_rdata;
          err  = v.port ? bus.rq1_err : bus.rq0_err;
        end
      end
      check({pfx, " rvalid"}, got, 1'b1);
      check({pfx, " rdata"}, data, v.exp_rdata);
      check({pfx, " err"}, err, v.exp_err);
      check({pfx, " latency"}, lat, v.exp_lat);
      check({pfx, " other_rvalid"}, wrong, 1'b0);
      wait_cyc();
      check({pfx, " pulse_end"}, {bus.rq0_rvalid, bus.rq1_rvalid, bus.rq0_err, bus.rq1_err}, 4'b0000);
      check({pfx, " rdata_hold"}, v.port ? bus.rq1_rdata : bus.rq0_rdata, v.exp_rdata);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs [10];

  initial begin : main
    int   order [8];
    int   rv_at [8];
    int   rem0, rem1, k, rv_cnt, exp_w;
    logic both_bad, w, wrong, got;
    vec_t v;

    //          port we   addr       wdata    busy rsp exp_rdata  err lat
    vecs[0] = '{1'b0, 1'b1, 24'h000010, 16'hBEEF, 0,  1'b1, 16'h0000, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b0, 24'h000010, 16'h0000, 0,  1'b1, 16'hBEEF, 1'b0, RD_LAT};
    vecs[2] = '{1'b1, 1'b1, 24'h000020, 16'h1234, 3,  1'b1, 16'h0000, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 24'h000020, 16'h0000, 0,  1'b1, 16'h1234, 1'b0, RD_LAT};
    vecs[4] = '{1'b0, 1'b0, 24'h000020, 16'h0000, 10, 1'b1, 16'h1234, 1'b0, RD_LAT};
    vecs[5] = '{1'b1, 1'b0, 24'h000010, 16'h0000, 0,  1'b1, 16'hBEEF, 1'b0, RD_LAT};
    vecs[6] = '{1'b1, 1'b1, 24'hABCDEF, 16'hA5A5, 0,  1'b1, 16'h0000, 1'b0, 0};
    vecs[7] = '{1'b0, 1'b0, 24'hABCDEF, 16'h0000, 2,  1'b1, 16'hA5A5, 1'b0, RD_LAT};
    vecs[8] = '{1'b0, 1'b1, 24'h000030, 16'h5A5A, 1,  1'b1, 16'h0000, 1'b0, 0};
    vecs[9] = '{1'b1, 1'b0, 24'h000040, 16'h0000, 0,  1'b0, 16'h0000, 1'b1, RD_TIMEOUT};

    rst = 1'b1;
    bus.rq0_valid = 1'b0; bus.rq0_we = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0;
    bus.rq1_valid = 1'b0; bus.rq1_we = 1'b0; bus.rq1_addr = '0; bus.rq1_wdata = '0;
    bus.sdr_busy = 1'b0; bus.sdr_rd_valid = 1'b0; bus.sdr_rdata = '0;
    repeat (3) wait_cyc();
    rst = 1'b0;
    check("reset_outputs", all_outs(), '0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      $display("vector %0d: port=%0d we=%0d addr=%06h done (miscompares so far %0d)",
               i, vecs[i].port, vecs[i].we, vecs[i].addr, n_bad);
    end

    // Stray read data while idle after the timeout must not produce rvalid.
    stray = 1'b1;
    wrong = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cyc();
      if (bus.rq0_rvalid || bus.rq1_rvalid) wrong = 1'b1;
    end
    check("stray_rd_valid", wrong, 1'b0);
    $display("sequence stray: done");

    // Contention: both requesters issue 4 back-to-back reads each.
    apply_reset();
    respond_en = 1'b1;
    busy_left  = 0;
    bus.rq0_we = 1'b0; bus.rq0_addr = 24'h000010;
    bus.rq1_we = 1'b0; bus.rq1_addr = 24'h000020;
    bus.rq0_valid = 1'b1;
    bus.rq1_valid = 1'b1;
    rem0 = 4; rem1 = 4; k = 0; rv_cnt = 0; both_bad = 1'b0;
    for (int i = 0; i < 300 && k < 8; i++) begin
      #1;
      if (bus.rq0_ready && bus.rq1_ready) both_bad = 1'b1;
      if (bus.rq0_rvalid || bus.rq1_rvalid) rv_cnt++;
      if (bus.rq0_ready || bus.rq1_ready) begin
        w = bus.rq1_ready;
        order[k] = int'(w);
        rv_at[k] = rv_cnt;
        k++;
        @(posedge clk);
        #1;
        if (w) begin rem1--; if (rem1 == 0) bus.rq1_valid = 1'b0; end
        else   begin rem0--; if (rem0 == 0) bus.rq0_valid = 1'b0; end
      end
      wait_cyc();
    end
    for (int i = 0; i < 20 && rv_cnt < 8; i++) begin
      if (bus.rq0_rvalid || bus.rq1_rvalid) rv_cnt++;
      if (rv_cnt < 8) wait_cyc();
    end
    bus.rq0_valid = 1'b0;
    bus.rq1_valid = 1'b0;
    check("contend_grants", k, 8);
    for (int j = 0; j < 8; j++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      exp_w = j % 2;
`else
      exp_w = (j < 4) ? 0 : 1;
`endif
      if (j < k) begin
        check($sformatf("contend_order%0d", j), order[j], exp_w);
        check($sformatf("contend_serial%0d", j), rv_at[j], j);
      end
    end
    check("contend_both_ready", both_bad, 1'b0);
    check("contend_rvalids", rv_cnt, 8);
    check("contend_route", {bus.rq0_rdata, bus.rq1_rdata}, {16'hBEEF, 16'h1234});
    $display("sequence contention: done (miscompares so far %0d)", n_bad);

    // Reset while a read is waiting for data.
    wait_cyc();
    respond_en = 1'b0;
    bus.rq1_we = 1'b0; bus.rq1_addr = 24'h000050; bus.rq1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (bus.rq1_ready) got = 1'b1; else wait_cyc();
    end
    check("rst_seq_grant", got, 1'b1);
    @(posedge clk);
    #1;
    bus.rq1_valid = 1'b0;
    repeat (6) wait_cyc();
    rst = 1'b1;
    wait_cyc();
    rst = 1'b0;
    check("rst_mid_outputs", all_outs(), '0);
    wrong = 1'b0;
    for (int i = 0; i < RD_TIMEOUT + 16; i++) begin
      wait_cyc();
      if (bus.rq0_rvalid || bus.rq1_rvalid) wrong = 1'b1;
    end
    check("rst_mid_no_rvalid", wrong, 1'b0);
    v = '{1'b0, 1'b0, 24'h000010, 16'h0000, 0, 1'b1, 16'hBEEF, 1'b0, RD_LAT};
    run_vec(v, "post_rst");
    $display("sequence mid-read reset: done (miscompares so far %0d)", n_bad);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
